alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Integer ALU with a sequential multiply/divide unit writing HI/LO registers.
// Single-cycle ops are purely combinational; mult/div iterate one bit per cycle.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [SHW-1:0]   shamt,
  input  logic [4:0]       ALUop,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             ZeroF,
  output logic             OvF,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [1:0]       state_o
);

  // Handshake: a HI/LO-class ALUop is offered when in_valid=1 and is taken at
  // the rising edge unless stall=1 (busy iterating); a stalled op has no effect
  // and must be held upstream. Single-cycle ops never use in_valid or stall.

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_SRL   = 5'b01000;
  localparam logic [4:0] OP_SRA   = 5'b01001;
  localparam logic [4:0] OP_ADDU  = 5'b01010;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_SUBU  = 5'b01110;
  localparam logic [4:0] OP_SLL   = 5'b01111;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] add_res, sub_res, sra_res, alu_res;
  logic             slt_bit, ovf;

  assign add_res = x + y;
  assign sub_res = x - y;
  assign sra_res = $signed(y) >>> shamt;
  assign slt_bit = $signed(x) < $signed(y);

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (ALUop)
      OP_AND:  alu_res = x & y;
      OP_OR:   alu_res = x | y;
      OP_XOR:  alu_res = x ^ y;
      OP_NOR:  alu_res = ~(x | y);
      OP_ADD: begin
        alu_res = add_res;
        ovf     = (x[WIDTH-1] == y[WIDTH-1]) && (add_res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        ovf     = (x[WIDTH-1] != y[WIDTH-1]) && (sub_res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL:  alu_res = y << shamt;
      OP_SRL:  alu_res = y >> shamt;
      OP_SRA:  alu_res = sra_res;
      OP_ADDU: alu_res = add_res;
      OP_SUBU: alu_res = sub_res;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign result = alu_res;
  assign ZeroF  = (alu_res == '0);
  assign OvF    = ovf;

  // ---------------- mult/div operand preparation ----------------
  logic             is_md_op, signed_op, is_div_op;
  logic [WIDTH-1:0] abs_x, abs_y;

  assign is_md_op  = (ALUop[4:2] == 3'b100);
  assign signed_op = ~ALUop[0];
  assign is_div_op = ALUop[1];
  assign abs_x     = (signed_op && x[WIDTH-1]) ? -x : x;
  assign abs_y     = (signed_op && y[WIDTH-1]) ? -y : y;

  // ---------------- one iteration step on magnitudes ----------------
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] mul_addend, div_sub, step_hi, step_lo;
  logic             div_ge;

  assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
  assign div_sh     = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge     = div_sh >= {1'b0, opnd_q};
  // The true difference is below the divisor, so WIDTH bits hold it exactly.
  assign div_sub    = div_sh[WIDTH-1:0] - opnd_q;

  always_comb begin
    if (is_div_q) begin
      step_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up of the final step ----------------
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -step_lo : step_lo;
  assign rem_fix  = rneg_q ? -step_hi : step_hi;

  always_comb begin
    if (!is_div_q) begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      // opnd_q carries the raw dividend when the divisor was zero
      fin_hi = opnd_q;
      fin_lo = '1;
    end else begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (in_valid && is_md_op) begin
          state_d  = S_BUSY;
          cnt_d    = '0;
          is_div_d = is_div_op;
          neg_d    = signed_op && (x[WIDTH-1] ^ y[WIDTH-1]);
          rneg_d   = signed_op && x[WIDTH-1];
          dz_d     = is_div_op && (y == '0);
          acc_hi_d = '0;
          acc_lo_d = is_div_op ? abs_x : abs_y;
          opnd_d   = is_div_op ? ((y == '0) ? x : abs_y) : abs_x;
        end else if (in_valid && ALUop == OP_MTHI) begin
          hi_d = x;
        end else if (in_valid && ALUop == OP_MTLO) begin
          lo_d = x;
        end
      end
      S_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  assign busy    = (state_q == S_BUSY);
  assign done    = (state_q == S_DONE);
  assign stall   = busy && (ALUop[4:3] == 2'b10) && in_valid;
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized bench for alu_muldiv: WIDTH=32 instance plus a WIDTH=16 instance,
// checked against an arithmetic reference model and an expected HI/LO queue.
module tb_alu_muldiv;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_SRL   = 5'b01000;
  localparam logic [4:0] OP_SRA   = 5'b01001;
  localparam logic [4:0] OP_ADDU  = 5'b01010;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_SUBU  = 5'b01110;
  localparam logic [4:0] OP_SLL   = 5'b01111;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] x, y, result;
  logic [4:0]  shamt, ALUop;
  logic        in_valid, ZeroF, OvF, busy, done, stall;
  logic [1:0]  st32;

  logic [15:0] x16, y16, result16;
  logic [3:0]  shamt16;
  logic [4:0]  op16;
  logic        iv16, zf16, of16, busy16, done16, stall16;
  logic [1:0]  st16;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .shamt(shamt), .ALUop(ALUop),
    .in_valid(in_valid), .result(result), .ZeroF(ZeroF), .OvF(OvF),
    .busy(busy), .done(done), .stall(stall), .state_o(st32)
  );

  alu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .x(x16), .y(y16), .shamt(shamt16), .ALUop(op16),
    .in_valid(iv16), .result(result16), .ZeroF(zf16), .OvF(of16),
    .busy(busy16), .done(done16), .stall(stall16), .state_o(st16)
  );

  // ---------------- scoreboard ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint      sa, sb, s;
    logic [31:0] r;
    logic        ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    ov = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  begin s = sa + sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      OP_SUB:  begin s = sa - sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  begin s = sb >>> sh; r = s[31:0]; end
      OP_ADDU: r = a + b;
      OP_SUBU: r = a - b;
      OP_MFHI: r = m_hi;
      OP_MFLO: r = m_lo;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  // Returns {HI, LO}, each zero-extended from w bits.
  function automatic logic [63:0] ref_muldiv(input int w, input logic [4:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, hi, lo;
    logic [63:0] up, ext;
    longint      sa, sb, p, q, r;
    mask = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    ext  = ~{32'h0, mask};
    sa   = a[w-1] ? longint'({32'h0, a} | ext) : longint'({32'h0, a});
    sb   = b[w-1] ? longint'({32'h0, b} | ext) : longint'({32'h0, b});
    hi   = '0;
    lo   = '0;
    case (op)
      OP_MULT:  begin p = sa * sb; hi = 32'(p >>> w) & mask; lo = 32'(p) & mask; end
      OP_MULTU: begin up = {32'h0, a} * {32'h0, b}; hi = 32'(up >> w) & mask; lo = 32'(up) & mask; end
      OP_DIV: begin
        if (b == 0) begin lo = mask; hi = a; end
        else begin q = sa / sb; r = sa % sb; hi = 32'(r) & mask; lo = 32'(q) & mask; end
      end
      default: begin
        if (b == 0) begin lo = mask; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
    return {hi, lo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_alu(input string tag);
    logic [32:0] e;
    #1;
    e = ref_alu(ALUop, x, y, shamt);
    check_eq({tag, "_res"}, result, e[31:0]);
    check_eq({tag, "_ovf"}, OvF, e[32]);
    check_eq({tag, "_zero"}, ZeroF, e[31:0] == 0);
  endtask

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    x = a; y = b; ALUop = op; in_valid = 1'b1;
    exp_q.push_back(ref_muldiv(32, op, a, b));
    tick();
    in_valid = 1'b0;
    ALUop = OP_AND;
  endtask

  // Walks the 32 busy cycles (probing stall or single-cycle ops), stops in the done cycle.
  task automatic wait_done(input int mode);
    logic [63:0] e;
    for (int k = 1; k <= 32; k++) begin
      if (mode == 1) begin
        ALUop = k[0] ? OP_MULT : OP_MFLO;
        x = $urandom; y = $urandom; in_valid = 1'b1;
        #1;
        check_eq("stall_busy", stall, 1'b1);
        if (!k[0]) check_eq("mflo_busy", result, m_lo);
      end else begin
        ALUop = 5'($urandom_range(0, 15));
        x = $urandom; y = $urandom; shamt = 5'($urandom_range(0, 31));
        in_valid = 1'($urandom_range(0, 1));
        check_alu("alu_busy");
        check_eq("nostall_busy", stall, 1'b0);
      end
      check_eq("busy_cyc", busy, 1'b1);
      check_eq("done_early", done, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    ALUop = OP_MFHI;
    #1;
    check_eq("done_pulse", done, 1'b1);
    check_eq("busy_at_done", busy, 1'b0);
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    check_eq("hi_at_done", result, m_hi);
    ALUop = OP_MFLO;
    #1;
    check_eq("lo_at_done", result, m_lo);
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] e;
    e = ref_muldiv(16, op, {16'h0, a}, {16'h0, b});
    x16 = a; y16 = b; op16 = op; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    op16 = OP_MFHI;
    for (int k = 1; k <= 16; k++) begin
      #1;
      check_eq("w16_busy", busy16, 1'b1);
      check_eq("w16_done_early", done16, 1'b0);
      tick();
    end
    #1;
    check_eq("w16_done", done16, 1'b1);
    check_eq("w16_hi", result16, e[47:32]);
    op16 = OP_MFLO;
    #1;
    check_eq("w16_lo", result16, e[15:0]);
    tick();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'(32'($urandom_range(0, 20)) - 32'd10);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    x = '0; y = '0; shamt = '0; ALUop = OP_AND; in_valid = 1'b0;
    x16 = '0; y16 = '0; shamt16 = '0; op16 = OP_AND; iv16 = 1'b0;

    // combinational ALU while reset is held
    x = 32'h7fff_ffff; y = 32'h1; ALUop = OP_ADD;
    check_alu("add_in_reset");
    tick();
    tick();
    ALUop = OP_MFLO; in_valid = 1'b1;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_lo", result, 32'h0);
    ALUop = OP_MFHI;
    #1;
    check_eq("rst_hi", result, 32'h0);
    rst = 1'b0; in_valid = 1'b0;

    // directed single-cycle cases
    x = 32'h7fff_ffff; y = 32'h1; ALUop = OP_ADD;
    check_alu("add_ovf");
    check_eq("add_ovf_val", result, 32'h8000_0000);
    x = 32'd5; y = 32'd5; ALUop = OP_SUB;
    check_alu("sub_zero");
    check_eq("sub_zero_flag", ZeroF, 1'b1);
    x = 32'h8000_0000; y = 32'h1; ALUop = OP_SUB;
    check_alu("sub_ovf");
    tick();

    for (int i = 0; i < 150; i++) begin
      ALUop = 5'($urandom_range(0, 15));
      x = pick_val(); y = pick_val(); shamt = 5'($urandom_range(0, 31));
      in_valid = 1'($urandom_range(0, 1));
      check_alu("alu_rand");
      tick();
    end
    in_valid = 1'b0;

    // directed mult/div, with stall probing during the first one
    start_op(OP_MULT, 32'hffff_fffe, 32'd3);
    wait_done(1);
    tick();
    start_op(OP_DIV, 32'hffff_fff9, 32'd2);
    wait_done(0);
    tick();
    start_op(OP_DIVU, 32'd7, 32'd0);
    wait_done(0);
    // issued in the done cycle: restarts immediately
    start_op(OP_DIV, 32'h8000_0000, 32'hffff_ffff);
    wait_done(1);
    start_op(OP_DIV, 32'hffff_fff9, 32'd0);
    wait_done(0);
    // mthi in the done cycle
    a = $urandom;
    x = a; ALUop = OP_MTHI; in_valid = 1'b1;
    #1;
    check_eq("mthi_res", result, 32'h0);
    tick();
    m_hi = a; in_valid = 1'b0; ALUop = OP_MFHI;
    #1;
    check_eq("mthi_done_hi", result, m_hi);
    tick();

    for (int i = 0; i < 24; i++) begin
      op = 5'({3'b100, 2'($urandom_range(0, 3))});
      a = pick_val(); b = pick_val();
      start_op(op, a, b);
      wait_done(int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // mtlo/mthi from idle
    a = $urandom; b = $urandom;
    x = a; ALUop = OP_MTLO; in_valid = 1'b1;
    #1;
    check_eq("mtlo_res", result, 32'h0);
    tick();
    m_lo = a;
    x = b; ALUop = OP_MTHI;
    tick();
    m_hi = b; in_valid = 1'b0; ALUop = OP_MFLO;
    #1;
    check_eq("mtlo_lo", result, m_lo);
    ALUop = OP_MFHI;
    #1;
    check_eq("mthi_hi", result, m_hi);

    // reset in the middle of a multu, with an mthi competing
    start_op(OP_MULTU, 32'hffff_ffff, 32'hffff_ffff);
    for (int k = 1; k < 10; k++) tick();
    rst = 1'b1; x = 32'h1234_5678; ALUop = OP_MTHI; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    void'(exp_q.pop_back());
    m_hi = '0; m_lo = '0;
    ALUop = OP_MFHI;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_hi", result, m_hi);
    ALUop = OP_MFLO;
    #1;
    check_eq("abort_lo", result, m_lo);
    for (int k = 0; k < 40; k++) begin
      check_eq("abort_no_done", done, 1'b0);
      tick();
    end

    // narrow instance
    run16(OP_MULTU, 16'hffff, 16'hffff);
    for (int i = 0; i < 8; i++) begin
      run16(5'({3'b100, 2'($urandom_range(0, 3))}), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
